rc_capture_sched: RTL and testbench
===================================

RC_CAPTURE_SCHED -- requirements
Module: rc_capture_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of RC PWM input channels (1..16).
REQ-002 SHALL have parameter CLK_PER_US, default 50: S_AXI_ACLK cycles per microsecond tick.
REQ-003 SHALL have parameter MIN_US, default 800: lowest in-range pulse width in us.
REQ-004 SHALL have parameter MAX_US, default 2200: highest in-range pulse width in us.
REQ-005 SHALL have parameter TIMEOUT_US, default 25000: failsafe silence limit in us (below 65535).
REQ-006 SHALL have port S_AXI_ACLK, input, 1: the only clock; every register updates on its rising edge.
REQ-007 SHALL have port S_AXI_ARESETN, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port rc_in, input, NUM_CH: asynchronous PWM inputs.
REQ-009 SHALL have port wr_ready, input, 1: register-bank write port free this cycle.
REQ-010 SHALL have port wr_en, output, 1: commit strobe.
REQ-011 SHALL have port wr_addr, output, 4: channel index being committed.
REQ-012 SHALL have port wr_data, output, 32: bit 31 in-range, bit 30 failsafe, bit 29 overrun, bits 28:16 zero, bits 15:0 width in us.
REQ-013 SHALL have port overrun_any, output, 1: OR of all per-channel overrun flags.

Function
REQ-014 SHALL pass each rc_in bit through a 2-flop synchronizer and detect edges on the synchronized value (3 cycles input-to-edge).
REQ-015 SHALL generate a 1-cycle us_tick when the prescaler equals CLK_PER_US-1, then wrap the prescaler to 0.
REQ-016 SHALL run a per-channel 2-state FSM: IDLE, then HIGH on a rising edge; HIGH, then IDLE on a falling edge.
REQ-017 SHALL clear the width counter on a rising edge, increment it on us_tick while HIGH, and saturate it at 0xFFFF.
REQ-018 SHALL latch the width into the channel result on a falling edge and set pending.
REQ-019 SHALL set in-range when MIN_US <= width <= MAX_US, and clear the failsafe bit, for each latched result.
REQ-020 SHALL keep a per-channel silence counter: cleared on a rising edge, incremented on us_tick, saturating.
REQ-021 SHALL load a failsafe result when the silence counter reaches TIMEOUT_US: width 0, in-range 0, failsafe 1, pending set.
REQ-022 SHALL load that failsafe result exactly once per silence period and re-arm it only after the next rising edge.
REQ-023 SHALL overwrite the result when a new result arrives while pending is still set, and set that channel's sticky overrun flag.
REQ-024 SHALL arbitrate pending channels round-robin: search starts at last granted index + 1, modulo NUM_CH.
REQ-025 SHALL grant one channel in a cycle where wr_ready=1 and a channel is pending.
REQ-026 SHALL, in the grant cycle, register wr_en=1, wr_addr and wr_data; the commit appears on the outputs the next cycle.
REQ-027 SHALL clear the granted channel's pending and overrun flags in the grant cycle, with wr_data carrying the pre-clear overrun value.
REQ-028 SHALL hold wr_en=0 in every cycle without a grant; when wr_ready=0, pending results persist without loss.
REQ-029 SHALL commit the new value when a result arrives for the granted channel in the grant cycle: keep pending set, with no overrun.
REQ-030 SHALL never grant more than one channel per cycle, and SHALL never grant a channel index >= NUM_CH.

Reset
REQ-031 SHALL, while S_AXI_ARESETN=0 at a clock edge, clear: prescaler, synchronizers, all FSMs (to IDLE), counters, results, pending, overrun, the round-robin pointer (last granted = NUM_CH-1), wr_en, wr_addr, wr_data and overrun_any.
REQ-032 SHALL discard any pulse in progress when reset is asserted mid-pulse; the first capture after reset requires a fresh rising edge.

Verification
REQ-033 SHALL pass this scenario: ch0 high for 1500 us, wr_ready=1 -> one commit, wr_addr=0, wr_data=0x800005DC, within 5 cycles of the falling edge.
REQ-034 SHALL pass this scenario: ch2 high for 700 us, then ch2 high for 2300 us -> two commits: 0x000002BC, then 0x000008FC.
REQ-035 SHALL pass this scenario: ch1 idle 25000 us after one pulse -> one commit with wr_data=0x40000000; no further commit until a new pulse arrives.
REQ-036 SHALL pass this scenario: ch0, ch3 and ch5 falling edges in the same cycle, wr_ready=1 -> commits on consecutive cycles in order 0, 3, 5.
REQ-037 SHALL pass this scenario: wr_ready=0 across two 1000 us pulses on ch4, then wr_ready=1 -> single commit 0xA00003E8, and overrun_any returns to 0 afterwards.
REQ-038 SHALL pass this scenario: reset asserted 500 us into a ch6 pulse -> no ch6 commit; the next full 1200 us pulse commits 0x800004B0.

Source files
------------

// File: rtl/rc_capture_sched.sv
// Multi-channel RC PWM pulse-width capture with failsafe detection and a
// round-robin scheduler that commits one channel result per cycle to a register bank.
module rc_capture_sched #(
    parameter int NUM_CH     = 8,
    parameter int CLK_PER_US = 50,
    parameter int MIN_US     = 800,
    parameter int MAX_US     = 2200,
    parameter int TIMEOUT_US = 25000
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic [NUM_CH-1:0] rc_in,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [3:0]        wr_addr,
    output logic [31:0]       wr_data,
    output logic              overrun_any
);

    localparam int            PW       = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_US - 1);
    localparam logic [15:0]   MIN_W    = 16'(MIN_US);
    localparam logic [15:0]   MAX_W    = 16'(MAX_US);
    localparam logic [15:0]   TMO_W    = 16'(TIMEOUT_US);

    typedef enum logic {ST_IDLE, ST_HIGH} ch_state_e;

    logic [PW-1:0]     presc_q, presc_d;
    logic [1:0]        warm_q, warm_d;
    logic [NUM_CH-1:0] s1_q, s2_q, prev_q, low_seen_q, low_seen_d;
    logic [NUM_CH-1:0] fs_done_q, fs_done_d, pend_q, pend_d, ovr_q, ovr_d;
    logic [NUM_CH-1:0] res_inr_q, res_inr_d, res_fs_q, res_fs_d;
    logic [15:0]       width_q [NUM_CH];
    logic [15:0]       width_d [NUM_CH];
    logic [15:0]       sil_q   [NUM_CH];
    logic [15:0]       sil_d   [NUM_CH];
    logic [15:0]       res_w_q [NUM_CH];
    logic [15:0]       res_w_d [NUM_CH];
    ch_state_e         st_q    [NUM_CH];
    ch_state_e         st_d    [NUM_CH];
    logic [3:0]        last_q, last_d, wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d, ovr_any_q, ovr_any_d;

    logic              us_tick, sync_vld, gnt_vld;
    logic [NUM_CH-1:0] rise, fall, gnt_oh;
    logic [3:0]        gnt_idx;
    logic [4:0]        idx;
    logic [15:0]       pend_pad, gnt_pad;

    assign us_tick  = (presc_q == PRE_LAST);
    assign sync_vld = (warm_q == 2'd2);
    // A rise only counts once a genuine low has been sampled since reset, so a
    // line already high when reset releases cannot fake a fresh edge.
    assign rise     = low_seen_q & s2_q & ~prev_q;
    assign fall     = prev_q & ~s2_q;

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        idx      = '0;
        pend_pad = 16'(pend_q);
        if (wr_ready) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                idx = 5'(last_q) + 5'(k) + 5'd1;
                if (idx >= 5'(NUM_CH)) idx = idx - 5'(NUM_CH);
                if (!gnt_vld && pend_pad[idx[3:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = idx[3:0];
                end
            end
        end
        gnt_pad = '0;
        if (gnt_vld) gnt_pad[gnt_idx] = 1'b1;
        gnt_oh = gnt_pad[NUM_CH-1:0];
    end

    always_comb begin : ch_next
        logic [15:0] w_inc;
        logic        fs_load;
        logic        new_ev;
        presc_d    = us_tick ? '0 : presc_q + 1'b1;
        warm_d     = sync_vld ? warm_q : warm_q + 2'd1;
        low_seen_d = low_seen_q | ({NUM_CH{sync_vld}} & ~s2_q);
        fs_done_d  = fs_done_q;
        pend_d     = pend_q;
        ovr_d      = ovr_q;
        res_inr_d  = res_inr_q;
        res_fs_d   = res_fs_q;
        w_inc      = '0;
        fs_load    = 1'b0;
        new_ev     = 1'b0;
        wr_data_d  = wr_data_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            st_d[i]    = st_q[i];
            width_d[i] = width_q[i];
            sil_d[i]   = sil_q[i];
            res_w_d[i] = res_w_q[i];
            new_ev     = 1'b0;
            w_inc      = (us_tick && width_q[i] != 16'hFFFF) ? width_q[i] + 16'd1 : width_q[i];

            case (st_q[i])
                ST_IDLE: begin
                    if (rise[i]) begin
                        st_d[i]    = ST_HIGH;
                        width_d[i] = '0;
                    end
                end
                ST_HIGH: begin
                    width_d[i] = w_inc;
                    if (fall[i]) begin
                        st_d[i]      = ST_IDLE;
                        new_ev       = 1'b1;
                        res_w_d[i]   = w_inc;
                        res_inr_d[i] = (w_inc >= MIN_W) && (w_inc <= MAX_W);
                        res_fs_d[i]  = 1'b0;
                    end
                end
                default: st_d[i] = ST_IDLE;
            endcase

            if (rise[i]) begin
                sil_d[i]     = '0;
                fs_done_d[i] = 1'b0;
            end else if (us_tick && sil_q[i] != 16'hFFFF) begin
                sil_d[i] = sil_q[i] + 16'd1;
            end

            fs_load = !fs_done_q[i] && !rise[i] && (sil_q[i] >= TMO_W);
            if (fs_load) fs_done_d[i] = 1'b1;
            if (fs_load && !new_ev) begin
                new_ev       = 1'b1;
                res_w_d[i]   = '0;
                res_inr_d[i] = 1'b0;
                res_fs_d[i]  = 1'b1;
            end

            // A result landing on the channel being granted stays pending for the
            // next grant; the stored value is committed now, so nothing is lost.
            if (new_ev) begin
                pend_d[i] = 1'b1;
                ovr_d[i]  = gnt_oh[i] ? 1'b0 : (ovr_q[i] | pend_q[i]);
            end else if (gnt_oh[i]) begin
                pend_d[i] = 1'b0;
                ovr_d[i]  = 1'b0;
            end

            if (gnt_oh[i]) wr_data_d = {res_inr_q[i], res_fs_q[i], ovr_q[i], 13'd0, res_w_q[i]};
        end
        wr_en_d   = gnt_vld;
        wr_addr_d = gnt_vld ? gnt_idx : wr_addr_q;
        last_d    = gnt_vld ? gnt_idx : last_q;
        ovr_any_d = |ovr_d;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            presc_q    <= '0;
            warm_q     <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            prev_q     <= '0;
            low_seen_q <= '0;
            fs_done_q  <= '0;
            pend_q     <= '0;
            ovr_q      <= '0;
            res_inr_q  <= '0;
            res_fs_q   <= '0;
            last_q     <= 4'(NUM_CH - 1);
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            ovr_any_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                st_q[i]    <= ST_IDLE;
                width_q[i] <= '0;
                sil_q[i]   <= '0;
                res_w_q[i] <= '0;
            end
        end else begin
            presc_q    <= presc_d;
            warm_q     <= warm_d;
            s1_q       <= rc_in;
            s2_q       <= s1_q;
            prev_q     <= s2_q;
            low_seen_q <= low_seen_d;
            fs_done_q  <= fs_done_d;
            pend_q     <= pend_d;
            ovr_q      <= ovr_d;
            res_inr_q  <= res_inr_d;
            res_fs_q   <= res_fs_d;
            last_q     <= last_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            ovr_any_q  <= ovr_any_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                st_q[i]    <= st_d[i];
                width_q[i] <= width_d[i];
                sil_q[i]   <= sil_d[i];
                res_w_q[i] <= res_w_d[i];
            end
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign overrun_any = ovr_any_q;

endmodule

// File: tb/tb_rc_capture_sched.sv
// Directed bench for rc_capture_sched; one us per clock so each scenario runs
// in real microsecond units with a short simulation.
module tb_rc_capture_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  rc_in;
    logic        wr_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        overrun_any;

    int          n_checks = 0;
    int          n_fail   = 0;
    longint      cyc      = 0;

    int unsigned c_addr[$];
    logic [31:0] c_data[$];
    longint      c_cyc[$];

    rc_capture_sched #(
        .NUM_CH    (8),
        .CLK_PER_US(1),
        .MIN_US    (800),
        .MAX_US    (2200),
        .TIMEOUT_US(25000)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rstn),
        .rc_in        (rc_in),
        .wr_ready     (wr_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .overrun_any  (overrun_any)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            c_addr.push_back(int'(wr_addr));
            c_data.push_back(wr_data);
            c_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        c_addr.delete();
        c_data.delete();
        c_cyc.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] mask, input int w, output longint fall_at);
        rc_in = rc_in | mask;
        repeat (w) @(negedge clk);
        rc_in = rc_in & ~mask;
        fall_at = cyc;
    endtask

    initial begin
        longint      fall_at;
        int          n_ch1;
        int          n_fs;
        logic [31:0] d_ch1;
        logic [7:0]  seen;

        rc_in    = '0;
        wr_ready = 1'b1;
        rstn     = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_wr_addr", 32'(wr_addr), 32'h0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_overrun_any", 32'(overrun_any), 32'h0);
        rstn = 1'b1;
        repeat (6) @(negedge clk);

        // ch0 1500 us, in range
        clear_log();
        pulse(8'h01, 1500, fall_at);
        repeat (20) @(negedge clk);
        check("s1_count", 32'(c_data.size()), 32'd1);
        check("s1_addr", 32'(c_addr[0]), 32'd0);
        check("s1_data", c_data[0], 32'h800005DC);
        check("s1_latency_le5", 32'((c_cyc[0] - fall_at) <= 5 && c_cyc[0] > fall_at), 32'd1);

        // ch2 below then above range
        do_reset();
        clear_log();
        pulse(8'h04, 700, fall_at);
        repeat (20) @(negedge clk);
        pulse(8'h04, 2300, fall_at);
        repeat (20) @(negedge clk);
        check("s2_count", 32'(c_data.size()), 32'd2);
        check("s2_addr0", 32'(c_addr[0]), 32'd2);
        check("s2_data0", c_data[0], 32'h000002BC);
        check("s2_data1", c_data[1], 32'h000008FC);

        // ch1 pulse, then silence until failsafe; every silent channel also fails safe once
        do_reset();
        clear_log();
        pulse(8'h02, 1000, fall_at);
        repeat (20) @(negedge clk);
        check("s3_pulse_count", 32'(c_data.size()), 32'd1);
        check("s3_pulse_data", c_data[0], 32'h800003E8);
        clear_log();
        repeat (24200) @(negedge clk);
        n_ch1 = 0;
        n_fs  = 0;
        d_ch1 = '0;
        seen  = '0;
        for (int i = 0; i < c_data.size(); i++) begin
            if (c_addr[i] == 1) begin
                n_ch1++;
                d_ch1 = c_data[i];
            end
            if (c_data[i] == 32'h40000000) n_fs++;
            if (c_addr[i] < 8) seen[c_addr[i]] = 1'b1;
        end
        check("s3_fs_total", 32'(c_data.size()), 32'd8);
        check("s3_fs_ch1_count", 32'(n_ch1), 32'd1);
        check("s3_fs_ch1_data", d_ch1, 32'h40000000);
        check("s3_fs_all_data", 32'(n_fs), 32'd8);
        check("s3_fs_channels", 32'(seen), 32'h000000FF);
        clear_log();
        repeat (2000) @(negedge clk);
        check("s3_no_repeat", 32'(c_data.size()), 32'd0);
        pulse(8'h02, 1500, fall_at);
        repeat (20) @(negedge clk);
        check("s3_rearm_count", 32'(c_data.size()), 32'd1);
        check("s3_rearm_addr", 32'(c_addr[0]), 32'd1);
        check("s3_rearm_data", c_data[0], 32'h800005DC);

        // simultaneous falls on ch0, ch3, ch5
        do_reset();
        clear_log();
        pulse(8'h29, 1000, fall_at);
        repeat (20) @(negedge clk);
        check("s4_count", 32'(c_data.size()), 32'd3);
        check("s4_addr0", 32'(c_addr[0]), 32'd0);
        check("s4_addr1", 32'(c_addr[1]), 32'd3);
        check("s4_addr2", 32'(c_addr[2]), 32'd5);
        check("s4_data0", c_data[0], 32'h800003E8);
        check("s4_data2", c_data[2], 32'h800003E8);
        check("s4_consec01", 32'(c_cyc[1] - c_cyc[0]), 32'd1);
        check("s4_consec12", 32'(c_cyc[2] - c_cyc[1]), 32'd1);

        // back-pressure with overrun on ch4
        do_reset();
        clear_log();
        wr_ready = 1'b0;
        pulse(8'h10, 1000, fall_at);
        repeat (20) @(negedge clk);
        pulse(8'h10, 1000, fall_at);
        repeat (20) @(negedge clk);
        check("s5_held_count", 32'(c_data.size()), 32'd0);
        check("s5_overrun_set", 32'(overrun_any), 32'd1);
        wr_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("s5_count", 32'(c_data.size()), 32'd1);
        check("s5_addr", 32'(c_addr[0]), 32'd4);
        check("s5_data", c_data[0], 32'hA00003E8);
        check("s5_overrun_clear", 32'(overrun_any), 32'd0);

        // reset in the middle of a ch6 pulse
        do_reset();
        clear_log();
        rc_in[6] = 1'b1;
        repeat (500) @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (700) @(negedge clk);
        rc_in[6] = 1'b0;
        repeat (20) @(negedge clk);
        check("s6_discard", 32'(c_data.size()), 32'd0);
        pulse(8'h40, 1200, fall_at);
        repeat (20) @(negedge clk);
        check("s6_count", 32'(c_data.size()), 32'd1);
        check("s6_addr", 32'(c_addr[0]), 32'd6);
        check("s6_data", c_data[0], 32'h800004B0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
